// File: rtl/gcd_engine.sv
// GCD engine: two operands over a shared bus under a four-phase req/ack handshake.
// Optional Stein (binary) algorithm compiled in with GCD_BINARY_EN, selected per transaction by mode.
module gcd_engine #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req,
  input  logic [W-1:0] ab,
  input  logic         mode,
  output logic         ack,
  output logic [W-1:0] c,
  output logic [W-1:0] cycles,
  output logic         busy
);

  localparam int KW = $clog2(W + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_A  = 3'd1,
    WAIT_B  = 3'd2,
    LOAD_B  = 3'd3,
    COMPUTE = 3'd4,
    DONE    = 3'd5,
    RELEASE = 3'd6
  } state_t;

  state_t         state_r;
  logic [W-1:0]   a_r;
  logic [W-1:0]   b_r;
  logic [W-1:0]   count_r;
  logic           mode_r;
  logic [KW-1:0]  k_s;
  logic [W-1:0]   a_next_s;
  logic [W-1:0]   b_next_s;
  logic           k_inc_s;
  logic           done_s;
  logic [W-1:0]   result_s;
  logic [W-1:0]   count_inc_s;

`ifdef GCD_BINARY_EN
  localparam logic BIN_EN = 1'b1;
  logic [KW-1:0] k_r;

  // Shift count for the common power of two, cleared when B is loaded
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_r <= '0;
    end else if (state_r == WAIT_B && req) begin
      k_r <= '0;
    end else if (state_r == COMPUTE && !done_s && k_inc_s) begin
      k_r <= k_r + 1'b1;
    end else begin
      k_r <= k_r;
    end
  end

  assign k_s = k_r;
`else
  localparam logic BIN_EN = 1'b0;
  logic unused_k_inc_s;

  assign k_s            = '0;
  assign unused_k_inc_s = k_inc_s;
`endif

  // One compute step: termination test, result and next operand values
  always_comb begin
    a_next_s    = a_r;
    b_next_s    = b_r;
    k_inc_s     = 1'b0;
    done_s      = (a_r == '0) || (b_r == '0) || (a_r == b_r);
    result_s    = (a_r | b_r) << k_s;
    count_inc_s = (count_r == {W{1'b1}}) ? count_r : count_r + {{(W-1){1'b0}}, 1'b1};
    if (mode_r && !a_r[0] && !b_r[0]) begin
      a_next_s = a_r >> 1;
      b_next_s = b_r >> 1;
      k_inc_s  = 1'b1;
    end else if (mode_r && !a_r[0]) begin
      a_next_s = a_r >> 1;
    end else if (mode_r && !b_r[0]) begin
      b_next_s = b_r >> 1;
    end else if (a_r > b_r) begin
      a_next_s = a_r - b_r;
    end else begin
      b_next_s = b_r - a_r;
    end
  end

  // Handshake FSM with registered ack/busy and result capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      ack     <= 1'b0;
      busy    <= 1'b0;
      c       <= '0;
      cycles  <= '0;
      a_r     <= '0;
      b_r     <= '0;
      count_r <= '0;
      mode_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req) begin
            a_r     <= ab;
            ack     <= 1'b1;
            busy    <= 1'b1;
            state_r <= LOAD_A;
          end
        end
        LOAD_A: begin
          if (!req) begin
            ack     <= 1'b0;
            state_r <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (req) begin
            b_r     <= ab;
            mode_r  <= mode & BIN_EN;
            count_r <= '0;
            ack     <= 1'b1;
            state_r <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (!req) begin
            ack     <= 1'b0;
            state_r <= COMPUTE;
          end
        end
        COMPUTE: begin
          if (done_s) begin
            c       <= result_s;
            cycles  <= count_inc_s;
            ack     <= 1'b1;
            state_r <= DONE;
          end else begin
            a_r     <= a_next_s;
            b_r     <= b_next_s;
            count_r <= count_inc_s;
          end
        end
        DONE: begin
          if (req) begin
            ack     <= 1'b0;
            state_r <= RELEASE;
          end
        end
        RELEASE: begin
          if (!req) begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          ack     <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_engine.sv
// Directed bench for gcd_engine: W=16, W=8 and W=4 instances, hand-computed vectors.
module tb_gcd_engine;

  logic        clk;
  logic        reset;
  logic        req16, req8, req4;
  logic [15:0] ab;
  logic        mode;
  logic        ack16, ack8, ack4;
  logic        busy16, busy8, busy4;
  logic [15:0] c16, cyc16;
  logic [7:0]  c8, cyc8;
  logic [3:0]  c4, cyc4;

  int          sel;
  logic        ack_s, busy_s;
  logic [15:0] c_s, cyc_s;
  int          n_checks;
  int          n_pass;

  gcd_engine #(.W(16)) u16 (.clk(clk), .reset(reset), .req(req16), .ab(ab), .mode(mode),
                            .ack(ack16), .c(c16), .cycles(cyc16), .busy(busy16));
  gcd_engine #(.W(8))  u8  (.clk(clk), .reset(reset), .req(req8), .ab(ab[7:0]), .mode(mode),
                            .ack(ack8), .c(c8), .cycles(cyc8), .busy(busy8));
  gcd_engine #(.W(4))  u4  (.clk(clk), .reset(reset), .req(req4), .ab(ab[3:0]), .mode(mode),
                            .ack(ack4), .c(c4), .cycles(cyc4), .busy(busy4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    case (sel)
      0:       begin ack_s = ack16; busy_s = busy16; c_s = c16;          cyc_s = cyc16;          end
      1:       begin ack_s = ack8;  busy_s = busy8;  c_s = {8'd0, c8};   cyc_s = {8'd0, cyc8};   end
      default: begin ack_s = ack4;  busy_s = busy4;  c_s = {12'd0, c4};  cyc_s = {12'd0, cyc4};  end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic set_req(input logic v);
    case (sel)
      0:       req16 = v;
      1:       req8  = v;
      default: req4  = v;
    endcase
  endtask

  task automatic wait_ack(input logic v, input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack_s !== v && n < budget);
  endtask

  // Handshake A and B in; returns at the negedge before the LOAD_B->COMPUTE edge
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic m, input string tag);
    int n;
    @(negedge clk);
    ab = a;
    set_req(1'b1);
    wait_ack(1'b1, 5, n);
    check({tag, "_ack_a"}, ack_s, 1);
    ab = ~a;
    mode = ~m;
    set_req(1'b0);
    wait_ack(1'b0, 5, n);
    check({tag, "_ack_a_low"}, ack_s, 0);
    ab = b;
    mode = m;
    set_req(1'b1);
    wait_ack(1'b1, 5, n);
    check({tag, "_ack_b"}, ack_s, 1);
    ab = ~b;
    mode = ~m;
    set_req(1'b0);
  endtask

  task automatic finish_op(input logic [15:0] exp_c, input logic [15:0] exp_cyc,
                           input logic noisy, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (noisy) begin
        ab = ab ^ 16'h5a3c;
        mode = ~mode;
        if (n == 1) set_req(1'b1);
        if (n == 2) set_req(1'b0);
      end
    end while (ack_s !== 1'b1 && n < 400);
    check({tag, "_ack_done"}, ack_s, 1);
    check({tag, "_c"}, c_s, exp_c);
    check({tag, "_cycles"}, cyc_s, exp_cyc);
    check({tag, "_latency"}, n - 1, exp_cyc);
    repeat (3) @(negedge clk);
    check({tag, "_ack_hold"}, ack_s, 1);
    set_req(1'b1);
    wait_ack(1'b0, 5, n);
    check({tag, "_release_busy"}, busy_s, 1);
    set_req(1'b0);
    @(negedge clk);
    @(negedge clk);
    check({tag, "_idle_busy"}, busy_s, 0);
    check({tag, "_c_stable"}, c_s, exp_c);
  endtask

  task automatic txn(input int s, input logic [15:0] a, input logic [15:0] b, input logic m,
                     input logic [15:0] exp_c, input logic [15:0] exp_cyc, input string tag);
    sel = s;
    start_op(a, b, m, tag);
    finish_op(exp_c, exp_cyc, 1'b0, tag);
  endtask

  initial begin
    logic [15:0] bin_cyc;
    n_checks = 0;
    n_pass   = 0;
    sel   = 0;
    reset = 1'b1;
    req16 = 1'b0;
    req8  = 1'b0;
    req4  = 1'b0;
    ab    = 16'd0;
    mode  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ack", ack_s, 0);
    check("rst_busy", busy_s, 0);
    check("rst_c", c_s, 0);
    check("rst_cycles", cyc_s, 0);

`ifdef GCD_BINARY_EN
    bin_cyc = 16'd5;
`else
    bin_cyc = 16'd3;
`endif
    txn(0, 16'd12,  16'd18, 1'b0, 16'd6, 16'd3,  "sub_12_18");
    txn(0, 16'd12,  16'd18, 1'b1, 16'd6, bin_cyc, "bin_12_18");
    txn(0, 16'd0,   16'd0,  1'b0, 16'd0, 16'd1,  "zero_0_0");
    txn(0, 16'd0,   16'd7,  1'b0, 16'd7, 16'd1,  "zero_0_7");
    txn(0, 16'd8,   16'd0,  1'b1, 16'd8, 16'd1,  "zero_8_0");
    txn(1, 16'd255, 16'd1,  1'b0, 16'd1, 16'd255, "w8_255_1");
    txn(2, 16'd15,  16'd1,  1'b0, 16'd1, 16'd15, "w4_15_1");

    // Reset mid-COMPUTE discards the transaction and clears outputs
    sel = 0;
    start_op(16'd1000, 16'd3, 1'b0, "rst_mid");
    repeat (5) @(negedge clk);
    check("rst_mid_busy", busy_s, 1);
    reset = 1'b1;
    #1;
    check("rst_mid_ack", ack_s, 0);
    check("rst_mid_busy0", busy_s, 0);
    check("rst_mid_c", c_s, 0);
    check("rst_mid_cycles", cyc_s, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_idle", busy_s, 0);
    txn(0, 16'd21, 16'd14, 1'b0, 16'd7, 16'd3, "after_rst");

    // Bus/mode noise and a req pulse during COMPUTE
    sel = 0;
    start_op(16'd48, 16'd36, 1'b0, "noisy");
    finish_op(16'd12, 16'd4, 1'b1, "noisy");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gcd_engine.md
# gcd_engine

Parametrised successor to the lab GCD unit. It computes the greatest common divisor of two unsigned `W`-bit operands, delivered one at a time over a shared `ab` bus under a four-phase `req`/`ack` handshake. It reports the result together with the number of compute cycles taken. An optional binary (Stein) algorithm can be compiled in and selected per transaction with `mode`.

## Interface
- `W`, default 16: operand, result and cycle-counter width. Legal range is 2 to 32.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  1  request. Synchronous to `clk` and held by the requester per the handshake rules.
- `ab`  in  W  operand bus. Carries A during phase 1 and B during phase 2.
- `mode`  in  1  algorithm select, sampled with B: 0 = subtraction, 1 = binary.
- `ack`  out  1  acknowledge.
- `c`  out  W  GCD result. Valid while `ack` is high in DONE, and held until the next result.
- `cycles`  out  W  COMPUTE cycle count of the last transaction. Saturates at 2^W-1.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Internal registers: A, B, `k` (shift count, binary mode only), mode register, count.
- States and transitions:
  - IDLE → LOAD_A on `req`=1. A ← `ab`.
  - LOAD_A (`ack`=1) → WAIT_B on `req`=0.
  - WAIT_B → LOAD_B on `req`=1. B ← `ab`, mode register ← `mode`, count ← 0, `k` ← 0.
  - LOAD_B (`ack`=1) → COMPUTE on `req`=0.
  - COMPUTE: one step per cycle, count += 1 (saturating). On the terminating step: `c` ← result, `cycles` ← count+1 (saturating), then → DONE.
  - DONE (`ack`=1) → RELEASE on `req`=1.
  - RELEASE (`ack`=0) → IDLE on `req`=0.
- Termination check, evaluated first in each COMPUTE cycle: A=0, B=0 or A=B. Result = (A | B) << k.
- Subtraction step: if A>B then A ← A-B, else B ← B-A.
- Binary step, in priority order:
  - both even: A>>=1, B>>=1, k+=1;
  - A even: A>>=1;
  - B even: B>>=1;
  - otherwise the larger operand ← larger minus smaller.
- Arithmetic is unsigned W-bit. Subtraction never underflows. `k` is ⌈log2(W+1)⌉ bits, and the result never exceeds max(A,B).
- Boundary cases:
  - gcd(0,0)=0 and gcd(0,x)=x, both terminating in the first COMPUTE cycle.
  - `req` changes in states that do not examine it are ignored.
  - `ab` and `mode` are only sampled on the IDLE→LOAD_A and WAIT_B→LOAD_B edges.
- Reset, at any time including mid-COMPUTE:
  - state → IDLE;
  - `ack`=0, `busy`=0, `c`=0, `cycles`=0;
  - A, B, `k`, count cleared;
  - the transaction in progress is discarded.

## Timing
- `req` is registered into the state machine with no extra synchronizer. `ack` and `busy` are registered outputs.
- `ack` rises 1 cycle after `req` is sampled high in IDLE, WAIT_B or the final compute edge, and falls 1 cycle after `req` is sampled low.
- Latency from the LOAD_B→COMPUTE edge to `ack` high in DONE is exactly `cycles` clock cycles.
- `c` and `cycles` update on the same edge that raises `ack` in DONE. They stay stable through RELEASE, IDLE and the next phases until the next DONE.
- Worst case, subtraction mode: gcd(2^W-1, 1) takes 2^W-1 cycles.
- Worst case, binary mode: at most 2W+1 cycles.

## Configuration
- `GCD_BINARY_EN` defined:
  - binary datapath and `k` register are built;
  - `mode`=1 selects the Stein step.
- `GCD_BINARY_EN` undefined:
  - `mode` is ignored and treated as 0;
  - the `k` register is removed and the shift amount is constant 0;
  - the port list is unchanged.

## Test plan
- Reset with `req`=0 → `ack`=0, `busy`=0, `c`=0, `cycles`=0. Then W=16, A=12, B=18, `mode`=0 → `c`=6, `cycles`=3; `ack` stays high until `req` rises.
- With the macro defined, A=12, B=18, `mode`=1 → `c`=6, `cycles`=5. Without the macro, same stimulus → `c`=6, `cycles`=3.
- Zero operands: (0,0) → `c`=0, `cycles`=1. (0,7) → `c`=7, `cycles`=1. (8,0) in binary mode → `c`=8, `cycles`=1.
- W=8, A=255, B=1, `mode`=0 → `c`=1, `cycles`=255 with no wrap. W=4, A=15, B=1 → `c`=1, `cycles`=15 (saturated value).
- Assert `reset` for one cycle mid-COMPUTE on (1000,3) → IDLE immediately, all outputs 0. The next transaction (21,14) → `c`=7, `cycles`=3.
- Toggle `ab` and `mode` while in LOAD_A, LOAD_B and COMPUTE, and pulse `req` during COMPUTE → result unaffected: (48,36) gives `c`=12.
